mem_bus_sched: RTL

MEM_BUS_SCHED -- requirements
Module: mem_bus_sched

---
 rtl/mem_bus_sched.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_bus_sched.sv
// mem_bus_sched: arbitrates icache/dcache burst requests onto one memory port with starvation guard
module mem_bus_sched #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int BEATS      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_beat,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata
);
  localparam int OFF = $clog2(BEATS * DATA_W / 8);
  localparam int BW  = $clog2(BEATS);
  localparam int SW  = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t state, state_nx;
  logic owner_dc, we_q, grant, grant_dc, beat, last_beat, rd_beat;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] starve_cnt;
  always_comb begin
    grant     = state == IDLE && (ic_req || dc_req);
    grant_dc  = dc_req && !(ic_req && starve_cnt == SW'(STARVE_MAX));
    beat      = state == XFER && mem_beat;
    last_beat = beat && beat_cnt == BW'(BEATS - 1);
    rd_beat   = beat && !we_q;
    state_nx  = state == IDLE ? (grant ? REQ : IDLE) :
                state == REQ  ? (mem_ack ? XFER : REQ) :
                state == XFER ? (last_beat ? DONE : XFER) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_dc   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      ic_rdata   <= '0;
      dc_rdata   <= '0;
      ic_rvalid  <= 1'b0;
      dc_rvalid  <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner_dc   <= grant_dc;
        addr_q     <= grant_dc ? dc_addr : ic_addr;
        we_q       <= grant_dc && dc_we;
        starve_cnt <= !grant_dc ? '0 :
                      (ic_req && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
      end
      beat_cnt  <= (state == REQ && mem_ack) ? '0 : beat ? beat_cnt + 1'b1 : beat_cnt;
      ic_rvalid <= rd_beat && !owner_dc;
      dc_rvalid <= rd_beat && owner_dc;
      ic_rdata  <= (rd_beat && !owner_dc) ? mem_rdata : ic_rdata;
      dc_rdata  <= (rd_beat && owner_dc) ? mem_rdata : dc_rdata;
    end
  end
  assign mem_req   = state == REQ;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign mem_wdata = dc_wdata;
  assign dc_wready = beat && we_q;
  assign ic_done   = state == DONE && !owner_dc;
  assign dc_done   = state == DONE && owner_dc;
endmodule
